// File: rtl/delta_controller_input_loader.sv
// DRAM-to-Input-SRAM loader: fetches 32-bit words from DRAM, packs four into a 128-bit line
// and writes the lines to Input SRAM in channel/row/column order.
module delta_controller_input_loader #(
  parameter int unsigned MAX_INPUT_CHANNEL = 256,
  parameter int unsigned MAX_FEATURE_SIZE  = 256,
  parameter int unsigned ELEMS_PER_LINE    = 8,
  localparam int unsigned IcW = $clog2(MAX_INPUT_CHANNEL),
  localparam int unsigned SzW = $clog2(MAX_FEATURE_SIZE)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [IcW-1:0] IC_Num,
  input  logic [SzW-1:0] IRC_Size,
  input  logic [31:0]    input_start_address,
  output logic           DRAM_Read,
  output logic [31:0]    DRAM_Address,
  input  logic [31:0]    DRAM_ReadData,
  input  logic           DRAM_ReadDone,
  output logic [127:0]   Input_SRAM_w_d,
  output logic [31:0]    Input_SRAM_w_addr,
  output logic           Input_SRAM_w_en,
  input  logic           Input_SRAM_w_done,
  output logic           finished
);

  typedef enum logic [2:0] {StIdle, StCheck, StRd, StWr, StFinish} state_e;

  state_e         state_q, state_d;
  logic [IcW-1:0] ic_r_q, ic_r_d;
  logic [SzW-1:0] irc_r_q, irc_r_d;
  logic [SzW-1:0] col_q, col_d;
  logic [SzW-1:0] row_q, row_d;
  logic [IcW-1:0] ch_q, ch_d;
  logic [1:0]     k_q, k_d;
  logic [31:0]    dram_addr_q, dram_addr_d;
  logic [31:0]    sram_addr_q, sram_addr_d;
  logic [127:0]   line_q, line_d;

  logic [SzW-1:0] col_inc, row_inc;
  assign col_inc = col_q + SzW'(8);
  assign row_inc = row_q + SzW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ic_r_q      <= '0;
      irc_r_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      k_q         <= '0;
      dram_addr_q <= '0;
      sram_addr_q <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      ic_r_q      <= ic_r_d;
      irc_r_q     <= irc_r_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      k_q         <= k_d;
      dram_addr_q <= dram_addr_d;
      sram_addr_q <= sram_addr_d;
      line_q      <= line_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ic_r_d          = ic_r_q;
    irc_r_d         = irc_r_q;
    col_d           = col_q;
    row_d           = row_q;
    ch_d            = ch_q;
    k_d             = k_q;
    dram_addr_d     = dram_addr_q;
    sram_addr_d     = sram_addr_q;
    line_d          = line_q;
    DRAM_Read       = 1'b0;
    Input_SRAM_w_en = 1'b0;
    finished        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Sizes are rounded down to whole 8-element groups.
          ic_r_d      = IC_Num & ~IcW'(7);
          irc_r_d     = IRC_Size & ~SzW'(7);
          dram_addr_d = input_start_address;
          sram_addr_d = '0;
          col_d       = '0;
          row_d       = '0;
          ch_d        = '0;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (ic_r_q == '0 || irc_r_q == '0 || ch_q == ic_r_q) begin
          state_d = StFinish;
        end else begin
          k_d     = '0;
          state_d = StRd;
        end
      end
      StRd: begin
        DRAM_Read = 1'b1;
        if (DRAM_ReadDone) begin
          for (int i = 0; i < 4; i++) begin
            if (k_q == 2'(i)) line_d[32*i +: 32] = DRAM_ReadData;
          end
          dram_addr_d = dram_addr_q + 32'd4;
          if (k_q == 2'd3) state_d = StWr;
          else             k_d     = k_q + 2'd1;
        end
      end
      StWr: begin
        Input_SRAM_w_en = 1'b1;
        if (Input_SRAM_w_done) begin
          sram_addr_d = sram_addr_q + ELEMS_PER_LINE;
          if (col_inc == irc_r_q) begin
            col_d = '0;
            if (row_inc == irc_r_q) begin
              row_d = '0;
              ch_d  = ch_q + IcW'(1);
            end else begin
              row_d = row_inc;
            end
          end else begin
            col_d = col_inc;
          end
          state_d = StCheck;
        end
      end
      StFinish: begin
        finished = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign DRAM_Address      = dram_addr_q;
  assign Input_SRAM_w_addr = sram_addr_q;
  assign Input_SRAM_w_d    = line_q;

endmodule

// File: tb/tb_delta_controller_input_loader.sv
// Randomized bench for delta_controller_input_loader: DRAM/SRAM responders with programmable
// latency, and a linear-memory reference model of the expected line stream.
module tb_delta_controller_input_loader;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   IC_Num;
  logic [7:0]   IRC_Size;
  logic [31:0]  input_start_address;
  logic         DRAM_Read;
  logic [31:0]  DRAM_Address;
  logic [31:0]  DRAM_ReadData;
  logic         DRAM_ReadDone;
  logic [127:0] Input_SRAM_w_d;
  logic [31:0]  Input_SRAM_w_addr;
  logic         Input_SRAM_w_en;
  logic         Input_SRAM_w_done;
  logic         finished;

  delta_controller_input_loader dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .IC_Num              (IC_Num),
    .IRC_Size            (IRC_Size),
    .input_start_address (input_start_address),
    .DRAM_Read           (DRAM_Read),
    .DRAM_Address        (DRAM_Address),
    .DRAM_ReadData       (DRAM_ReadData),
    .DRAM_ReadDone       (DRAM_ReadDone),
    .Input_SRAM_w_d      (Input_SRAM_w_d),
    .Input_SRAM_w_addr   (Input_SRAM_w_addr),
    .Input_SRAM_w_en     (Input_SRAM_w_en),
    .Input_SRAM_w_done   (Input_SRAM_w_done),
    .finished            (finished)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int          rd_delay = 1, wr_delay = 1;
  bit          seq_mode = 1'b0;
  logic [31:0] seed = 32'h0, base = 32'h0;
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [127:0] wd_q[$];
  int          fin_cnt = 0, wen_cycles = 0, rd_cycles = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DRAM contents: either a counting sequence from the load base or an address hash.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (seq_mode) return seed + ((a - base) >> 2);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  int          rd_wait = 0;
  bit          rd_pend = 1'b0;
  logic [31:0] rd_hold;
  always @(posedge clock) begin
    #1;
    if (DRAM_Read) begin
      if (rd_pend) check("rd_addr_stable", {96'b0, DRAM_Address}, {96'b0, rd_hold});
      rd_hold = DRAM_Address;
      if (rd_wait >= rd_delay) begin
        DRAM_ReadDone = 1'b1;
        DRAM_ReadData = word_at(DRAM_Address);
        rd_q.push_back(DRAM_Address);
        rd_wait = 0;
        rd_pend = 1'b0;
      end else begin
        DRAM_ReadDone = 1'b0;
        rd_wait++;
        rd_pend = 1'b1;
      end
    end else begin
      DRAM_ReadDone = 1'b0;
      rd_wait = 0;
      rd_pend = 1'b0;
    end
  end

  int           wr_wait = 0;
  bit           wr_pend = 1'b0;
  logic [31:0]  wa_hold;
  logic [127:0] wd_hold;
  always @(posedge clock) begin
    #1;
    if (Input_SRAM_w_en) begin
      if (wr_pend) begin
        check("wr_addr_stable", {96'b0, Input_SRAM_w_addr}, {96'b0, wa_hold});
        check("wr_data_stable", Input_SRAM_w_d, wd_hold);
      end
      wa_hold = Input_SRAM_w_addr;
      wd_hold = Input_SRAM_w_d;
      if (wr_wait >= wr_delay) begin
        Input_SRAM_w_done = 1'b1;
        wa_q.push_back(Input_SRAM_w_addr);
        wd_q.push_back(Input_SRAM_w_d);
        wr_wait = 0;
        wr_pend = 1'b0;
      end else begin
        Input_SRAM_w_done = 1'b0;
        wr_wait++;
        wr_pend = 1'b1;
      end
    end else begin
      Input_SRAM_w_done = 1'b0;
      wr_wait = 0;
      wr_pend = 1'b0;
    end
  end

  always @(posedge clock) begin
    #1;
    if (finished)        fin_cnt++;
    if (Input_SRAM_w_en) wen_cycles++;
    if (DRAM_Read)       rd_cycles++;
  end

  task automatic run_load(input logic [7:0] ic, input logic [7:0] irc, input logic [31:0] addr,
                          input int rdd, input int wrd, input bit seq, input logic [31:0] sd,
                          input bit poke_start);
    int lines, ncyc;
    logic [127:0] exp_line;
    rd_delay = rdd; wr_delay = wrd; seq_mode = seq; seed = sd; base = addr;
    rd_q.delete(); wa_q.delete(); wd_q.delete(); fin_cnt = 0;
    IC_Num = ic; IRC_Size = irc; input_start_address = addr;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    // Sizes and address must have been latched; scramble the inputs.
    IC_Num = 8'($urandom); IRC_Size = 8'($urandom); input_start_address = $urandom;
    ncyc = 0;
    while (fin_cnt == 0 && ncyc < 40000) begin
      @(posedge clock); #2;
      ncyc++;
      start = (poke_start && ncyc == 50);
    end
    start = 1'b0;
    check("load_timeout", {127'b0, ncyc < 40000}, 128'd1);
    repeat (3) @(posedge clock);
    #2 check("finished_once", 128'(fin_cnt), 128'd1);
    lines = int'(ic & 8'hF8) * int'(irc & 8'hF8) * int'(irc & 8'hF8) / 8;
    check("line_count", 128'(wa_q.size()), 128'(lines));
    check("read_count", 128'(rd_q.size()), 128'(4 * lines));
    for (int j = 0; j < rd_q.size() && j < 4 * lines; j++)
      check("rd_addr", {96'b0, rd_q[j]}, {96'b0, addr + 32'(4 * j)});
    for (int i = 0; i < wa_q.size() && i < lines; i++) begin
      for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = word_at(addr + 32'(16 * i + 4 * k));
      check("wr_addr", {96'b0, wa_q[i]}, 128'(8 * i));
      check("wr_data", wd_q[i], exp_line);
    end
    if (lines > 0) begin
      check("last_rd_addr", {96'b0, rd_q[rd_q.size() - 1]}, {96'b0, addr + 32'(16 * lines - 4)});
      check("final_dram_addr", {96'b0, DRAM_Address}, {96'b0, addr + 32'(16 * lines)});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"},  {127'b0, DRAM_Read}, 128'd0);
    check({tag, "_daddr"}, {96'b0, DRAM_Address}, 128'd0);
    check({tag, "_wd"},    Input_SRAM_w_d, 128'd0);
    check({tag, "_waddr"}, {96'b0, Input_SRAM_w_addr}, 128'd0);
    check({tag, "_wen"},   {127'b0, Input_SRAM_w_en}, 128'd0);
    check({tag, "_fin"},   {127'b0, finished}, 128'd0);
  endtask

  initial begin
    int rc0, wc0, n;
    reset = 1'b0; start = 1'b0; IC_Num = '0; IRC_Size = '0; input_start_address = '0;
    DRAM_ReadData = '0; DRAM_ReadDone = 1'b0; Input_SRAM_w_done = 1'b0;
    #12 check_all_zero("reset");
    #10 reset = 1'b1;

    run_load(8'd8, 8'd8, 32'h1000, 1, 1, 1'b0, $urandom, 1'b0);
    run_load(8'd8, 8'd8, 32'h4000, 0, 0, 1'b1, 32'hA0, 1'b0);
    check("lane_order", wd_q[0], 128'h000000A3_000000A2_000000A1_000000A0);
    check("lane_addr", {96'b0, wa_q[0]}, 128'd0);
    run_load(8'd10, 8'd13, 32'h1000, 1, 1, 1'b0, $urandom, 1'b0);

    // Zero-size load: CHECK then FINISH, no traffic.
    rc0 = rd_cycles; wc0 = wen_cycles; fin_cnt = 0;
    IC_Num = 8'd8; IRC_Size = 8'd5; input_start_address = 32'h5000;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    check("zero_fin_c1", {127'b0, finished}, 128'd0);
    @(posedge clock); #1 check("zero_fin_c2", {127'b0, finished}, 128'd1);
    @(posedge clock); #1 check("zero_fin_c3", {127'b0, finished}, 128'd0);
    #2 check("zero_reads", 128'(rd_cycles - rc0), 128'd0);
    check("zero_writes", 128'(wen_cycles - wc0), 128'd0);

    run_load(8'd8, 8'd8, 32'h2000, 5, 3, 1'b0, $urandom, 1'b1);

    // Asynchronous reset during the third word of line 2.
    rd_delay = 5; wr_delay = 3; seq_mode = 1'b0; base = 32'h3000;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    IC_Num = 8'd8; IRC_Size = 8'd8; input_start_address = 32'h3000;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    while (rd_q.size() < 6 && n < 500) begin @(posedge clock); #2; n++; end
    check("reset_reach", {127'b0, n < 500}, 128'd1);
    @(posedge clock); #4 reset = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    rc0 = rd_cycles; wc0 = wen_cycles;
    repeat (5) @(posedge clock);
    #2 check("post_reset_reads", 128'(rd_cycles - rc0), 128'd0);
    check("post_reset_writes", 128'(wen_cycles - wc0), 128'd0);
    run_load(8'd8, 8'd8, 32'h3000, 1, 0, 1'b0, $urandom, 1'b0);

    run_load(8'd8, 8'd8, 32'hFFFF_FF00, 0, 0, 1'b0, $urandom, 1'b0);
    for (int t = 0; t < 3; t++)
      run_load(8'($urandom_range(0, 19)), 8'($urandom_range(0, 19)), $urandom & ~32'h3,
               $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, $urandom, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
